// File: rtl/qei_pkg.sv
// Shared constants and helpers for the multi-channel quadrature encoder interface.
package qei_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  // Returns {valid, up, illegal} for a transition between two {A,B} states.
  function automatic logic [2:0] stepEncode(input logic [1:0] prev, input logic [1:0] cur);
    logic [2:0] result;
    result = 3'b000;
    case ({prev, cur})
      {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: result = 3'b110;
      {S10, S00}, {S11, S10}, {S01, S11}, {S00, S01}: result = 3'b100;
      {S00, S11}, {S11, S00}, {S10, S01}, {S01, S10}: result = 3'b001;
      default:                                        result = 3'b000;
    endcase
    return result;
  endfunction

  function automatic int filtCntW(input int filtLen);
    return (filtLen < 1) ? 1 : $clog2(filtLen + 1);
  endfunction

endpackage

// File: rtl/qei_channel.sv
// One encoder channel: synchroniser, glitch filter, x4 decoder, wrapping
// position counter, index capture and sticky illegal-transition flag.
module qei_channel
  import qei_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [2:0]       abz_i,
  input  logic             idx_clr_en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_err_i,
  output logic [CNT_W-1:0] pos_o,
  output logic             dir_o,
  output logic [CNT_W-1:0] idx_pos_o,
  output logic             idx_evt_o,
  output logic             err_o
);

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       filt;
  logic [1:0]       prevAb_q;
  logic             prevZ_q, primed_q;
  logic [CNT_W-1:0] pos_q, pos_d, idxPos_q, idxPos_d, stepped;
  logic             dir_q, dir_d, idxEvt_q, idxEvt_d, err_q, err_d;
  logic [2:0]       step;
  logic             stepValid, stepUp, stepIllegal, zRise;

  if (FILT_LEN == 0) begin : g_nofilt
    assign filt = sync2_q;
  end else begin : g_filt
    localparam int FW = filtCntW(FILT_LEN);
    logic [FW-1:0] cnt_q [3];
    logic [2:0]    filt_q;

    // A line only follows its synchronised value after FILT_LEN disagreeing samples.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        filt_q <= '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (sync2_q[i] == filt_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == FW'(FILT_LEN - 1)) begin
            cnt_q[i]  <= '0;
            filt_q[i] <= sync2_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end

    assign filt = filt_q;
  end

  // primed_q suppresses decoding on the first post-reset sample, which only seeds prev.
  always_comb begin
    step        = stepEncode(prevAb_q, filt[2:1]);
    stepValid   = primed_q & step[2];
    stepUp      = step[1];
    stepIllegal = primed_q & step[0];
    zRise       = primed_q & filt[0] & ~prevZ_q;

    stepped = pos_q;
    if (stepValid) stepped = stepUp ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);

    pos_d    = stepped;
    dir_d    = stepValid ? stepUp : dir_q;
    idxPos_d = idxPos_q;
    idxEvt_d = 1'b0;
    err_d    = err_q;

    if (zRise) begin
      idxPos_d = stepped;
      idxEvt_d = 1'b1;
      if (idx_clr_en_i) pos_d = '0;
    end
    if (load_i) pos_d = load_val_i;

    if (stepIllegal)      err_d = 1'b1;
    else if (clear_err_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prevAb_q <= '0;
      prevZ_q  <= 1'b0;
      primed_q <= 1'b0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      idxPos_q <= '0;
      idxEvt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= abz_i;
      sync2_q  <= sync1_q;
      prevAb_q <= filt[2:1];
      prevZ_q  <= filt[0];
      primed_q <= 1'b1;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      idxPos_q <= idxPos_d;
      idxEvt_q <= idxEvt_d;
      err_q    <= err_d;
    end
  end

  assign pos_o     = pos_q;
  assign dir_o     = dir_q;
  assign idx_pos_o = idxPos_q;
  assign idx_evt_o = idxEvt_q;
  assign err_o     = err_q;

endmodule

// File: rtl/qei_multi.sv
// N-channel quadrature encoder interface; each channel is an independent
// qei_channel fed from its slice of the packed pin and control buses.
module qei_multi
  import qei_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*N_CH-1:0]     enc_abz,
  input  logic [N_CH-1:0]       idx_clr_en,
  input  logic [N_CH-1:0]       load,
  input  logic [CNT_W-1:0]      load_val,
  input  logic [N_CH-1:0]       clear_err,
  output logic [N_CH*CNT_W-1:0] pos,
  output logic [N_CH-1:0]       dir,
  output logic [N_CH*CNT_W-1:0] idx_pos,
  output logic [N_CH-1:0]       idx_evt,
  output logic [N_CH-1:0]       err
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    qei_channel #(
      .CNT_W   (CNT_W),
      .FILT_LEN(FILT_LEN)
    ) u_ch (
      .clk_i       (clk),
      .reset_i     (reset),
      .abz_i       (enc_abz[3*c +: 3]),
      .idx_clr_en_i(idx_clr_en[c]),
      .load_i      (load[c]),
      .load_val_i  (load_val),
      .clear_err_i (clear_err[c]),
      .pos_o       (pos[c*CNT_W +: CNT_W]),
      .dir_o       (dir[c]),
      .idx_pos_o   (idx_pos[c*CNT_W +: CNT_W]),
      .idx_evt_o   (idx_evt[c]),
      .err_o       (err[c])
    );
  end

endmodule

// File: tb/tb_qei_multi.sv
// Directed and randomised bench for qei_multi with a phase-arithmetic reference model.
module tb_qei_multi;

  localparam int N_CH     = 3;
  localparam int CNT_W    = 32;
  localparam int FILT_LEN = 3;
  localparam int LAT      = 2 + FILT_LEN + 1;
  localparam int W        = N_CH * CNT_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3*N_CH-1:0]     enc_abz;
  logic [N_CH-1:0]       idx_clr_en, load, clear_err;
  logic [CNT_W-1:0]      load_val;
  logic [N_CH*CNT_W-1:0] pos, idx_pos;
  logic [N_CH-1:0]       dir, idx_evt, err;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] mPos    [N_CH];
  logic [CNT_W-1:0] mIdxPos [N_CH];
  logic             mDir    [N_CH];
  logic             mErr    [N_CH];
  logic             mZ      [N_CH];
  int               mPhase  [N_CH];

  qei_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_abz   (enc_abz),
    .idx_clr_en(idx_clr_en),
    .load      (load),
    .load_val  (load_val),
    .clear_err (clear_err),
    .pos       (pos),
    .dir       (dir),
    .idx_pos   (idx_pos),
    .idx_evt   (idx_evt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int c, input logic a, input logic b, input logic z);
    enc_abz[3*c +: 3] = {a, b, z};
  endtask

  function automatic logic [CNT_W-1:0] posOf(input int c);
    return pos[c*CNT_W +: CNT_W];
  endfunction

  function automatic logic [CNT_W-1:0] idxPosOf(input int c);
    return idx_pos[c*CNT_W +: CNT_W];
  endfunction

  // Position within the 4-state cycle: 00=0, 10=1, 11=2, 01=3; +1 is an up step.
  function automatic int phaseOf(input logic a, input logic b);
    return a ? (b ? 2 : 1) : (b ? 3 : 0);
  endfunction

  function automatic logic [1:0] abOfPhase(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic modelStep(input int c, input logic a, input logic b, input logic z);
    int ph;
    int d;
    ph = phaseOf(a, b);
    d  = (ph - mPhase[c] + 4) % 4;
    if (d == 1) begin
      mPos[c] = mPos[c] + 1;
      mDir[c] = 1'b1;
    end else if (d == 3) begin
      mPos[c] = mPos[c] - 1;
      mDir[c] = 1'b0;
    end else if (d == 2) begin
      mErr[c] = 1'b1;
    end
    mPhase[c] = ph;
    if (z && !mZ[c]) begin
      mIdxPos[c] = mPos[c];
      if (idx_clr_en[c]) mPos[c] = '0;
    end
    mZ[c] = z;
  endtask

  initial begin
    logic [1:0] fwdSeq [4];
    fwdSeq[0] = 2'b10;
    fwdSeq[1] = 2'b11;
    fwdSeq[2] = 2'b01;
    fwdSeq[3] = 2'b00;

    reset      = 1'b1;
    enc_abz    = '0;
    idx_clr_en = '0;
    load       = '0;
    load_val   = '0;
    clear_err  = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checkOutput("reset_pos", pos, '0);
    checkOutput("reset_idx_pos", idx_pos, '0);
    checkOutput("reset_dir", W'(dir), '0);
    checkOutput("reset_idx_evt", W'(idx_evt), '0);
    checkOutput("reset_err", W'(err), '0);

    // Forward sequence on channel 0 with exact latency at each edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, fwdSeq[i][1], fwdSeq[i][0], 1'b0);
      tick(LAT - 1);
      checkOutput($sformatf("fwd_pre%0d", i), W'(posOf(0)), W'(i));
      tick(1);
      checkOutput($sformatf("fwd_post%0d", i), W'(posOf(0)), W'(i + 1));
      tick(10 - LAT);
    end
    checkOutput("fwd_dir0", W'(dir[0]), W'(1));
    checkOutput("fwd_pos1", W'(posOf(1)), '0);
    checkOutput("fwd_pos2", W'(posOf(2)), '0);

    // Reverse wrap on channel 1.
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    tick(LAT);
    checkOutput("wrap_pos1", W'(posOf(1)), W'(32'hFFFF_FFFF));
    checkOutput("wrap_dir1", W'(dir[1]), '0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    tick(LAT);
    checkOutput("unwrap_pos1", W'(posOf(1)), '0);
    tick(4);

    // Glitch rejection on channel 0: 2-cycle pulse dropped, 3-cycle pulse passes.
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick(2);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("glitch2_pos0", W'(posOf(0)), W'(4));
    checkOutput("glitch2_err0", W'(err[0]), '0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick(3);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(4);
    checkOutput("glitch3_up_pos0", W'(posOf(0)), W'(5));
    checkOutput("glitch3_up_dir0", W'(dir[0]), W'(1));
    tick(5);
    checkOutput("glitch3_dn_pos0", W'(posOf(0)), W'(4));
    checkOutput("glitch3_dn_dir0", W'(dir[0]), '0);

    // Illegal transitions and clear_err behaviour on channel 0.
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    tick(LAT - 1);
    checkOutput("illegal_pre_err0", W'(err[0]), '0);
    tick(1);
    checkOutput("illegal_err0", W'(err[0]), W'(1));
    checkOutput("illegal_pos0", W'(posOf(0)), W'(4));
    clear_err[0] = 1'b1;
    tick(1);
    clear_err[0] = 1'b0;
    checkOutput("clear_err0", W'(err[0]), '0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(LAT - 1);
    clear_err[0] = 1'b1;
    tick(1);
    clear_err[0] = 1'b0;
    checkOutput("set_wins_err0", W'(err[0]), W'(1));
    checkOutput("set_wins_pos0", W'(posOf(0)), W'(4));
    clear_err[0] = 1'b1;
    tick(1);
    clear_err[0] = 1'b0;
    checkOutput("clear_again_err0", W'(err[0]), '0);

    // Index capture on channel 2, first without clear, then with clear and a step.
    load_val = 32'h123;
    load[2]  = 1'b1;
    tick(1);
    load[2] = 1'b0;
    checkOutput("load_pos2", W'(posOf(2)), W'(32'h123));
    applyStimulus(2, 1'b0, 1'b0, 1'b1);
    tick(LAT - 1);
    checkOutput("idx_pre_evt2", W'(idx_evt[2]), '0);
    tick(1);
    checkOutput("idx_evt2", W'(idx_evt[2]), W'(1));
    checkOutput("idx_pos2", W'(idxPosOf(2)), W'(32'h123));
    checkOutput("idx_keep_pos2", W'(posOf(2)), W'(32'h123));
    tick(1);
    checkOutput("idx_evt2_end", W'(idx_evt[2]), '0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    tick(LAT + 2);
    idx_clr_en[2] = 1'b1;
    applyStimulus(2, 1'b1, 1'b0, 1'b1);
    tick(LAT);
    checkOutput("idxclr_evt2", W'(idx_evt[2]), W'(1));
    checkOutput("idxclr_idx_pos2", W'(idxPosOf(2)), W'(32'h124));
    checkOutput("idxclr_pos2", W'(posOf(2)), '0);
    idx_clr_en[2] = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    tick(LAT + 2);

    // Load beats a coincident up step on channel 0.
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick(LAT - 1);
    load_val = 32'h8000_0000;
    load[0]  = 1'b1;
    tick(1);
    load[0] = 1'b0;
    checkOutput("load_wins_pos0", W'(posOf(0)), W'(32'h8000_0000));
    checkOutput("load_wins_dir0", W'(dir[0]), W'(1));

    // Reset while edges are still in the synchroniser/filter pipeline.
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 1'b1);
    tick(3);
    reset   = 1'b1;
    enc_abz = '0;
    tick(1);
    checkOutput("midreset_pos", pos, '0);
    checkOutput("midreset_idx_pos", idx_pos, '0);
    checkOutput("midreset_flags", W'({dir, idx_evt, err}), '0);
    tick(1);
    reset = 1'b0;
    tick(LAT + 4);
    checkOutput("postreset_pos", pos, '0);
    checkOutput("postreset_flags", W'({dir, idx_pos != '0, err}), '0);

    // Randomised walk on all channels against the phase model.
    for (int c = 0; c < N_CH; c++) begin
      mPos[c]    = '0;
      mIdxPos[c] = '0;
      mDir[c]    = 1'b0;
      mErr[c]    = 1'b0;
      mZ[c]      = 1'b0;
      mPhase[c]  = 0;
    end
    idx_clr_en = N_CH'($urandom_range(0, (1 << N_CH) - 1));
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        int kind;
        int delta;
        logic [1:0] ab;
        logic z;
        kind  = int'($urandom_range(0, 7));
        delta = (kind == 0) ? 0 : (kind <= 3) ? 1 : (kind <= 6) ? 3 : 2;
        ab    = abOfPhase((mPhase[c] + delta) % 4);
        z     = ($urandom_range(0, 2) == 0) ? ~mZ[c] : mZ[c];
        applyStimulus(c, ab[1], ab[0], z);
        modelStep(c, ab[1], ab[0], z);
      end
      tick(LAT + int'($urandom_range(0, 3)));
      for (int c = 0; c < N_CH; c++) begin
        checkOutput($sformatf("rnd%0d_pos%0d", it, c), W'(posOf(c)), W'(mPos[c]));
        checkOutput($sformatf("rnd%0d_dir%0d", it, c), W'(dir[c]), W'(mDir[c]));
        checkOutput($sformatf("rnd%0d_err%0d", it, c), W'(err[c]), W'(mErr[c]));
        checkOutput($sformatf("rnd%0d_idx_pos%0d", it, c), W'(idxPosOf(c)), W'(mIdxPos[c]));
      end
      for (int c = 0; c < N_CH; c++) begin
        clear_err[c] = mErr[c];
        mErr[c]      = 1'b0;
      end
      tick(1);
      clear_err = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qei_multi.md
Name: qei_multi

Overview:
N-channel quadrature encoder interface with A/B/Z inputs per channel. Each channel synchronises and glitch-filters its lines, performs x4 decode into a wrapping signed position counter, flags illegal transitions, and captures the position on index edges, optionally zeroing the counter there. It sits between the encoder pins and the servo control logic and replaces the single-channel QEI, serving all motor axes from one instance.

Parameters:
N_CH, 3, number of encoder channels
CNT_W, 32, position counter width in bits; two's complement, wraps modulo 2^CNT_W
FILT_LEN, 3, consecutive synchronised samples that must agree before a filtered line changes; 0 bypasses the filter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enc_abz  in  3*N_CH  raw encoder pins, channel c at bits [3c+2:3c] = {A,B,Z}
idx_clr_en  in  N_CH  per channel: 1 zeroes the counter on each index edge
load  in  N_CH  per channel: 1-cycle pulse loads load_val into pos
load_val  in  CNT_W  value used by load (shared by all channels)
clear_err  in  N_CH  per channel: 1-cycle pulse clears err
pos  out  N_CH*CNT_W  position, channel c at [CNT_W*(c+1)-1:CNT_W*c]
dir  out  N_CH  direction of the last valid count: 1 = up
idx_pos  out  N_CH*CNT_W  position captured on the last index edge
idx_evt  out  N_CH  1-cycle pulse on each index capture
err  out  N_CH  sticky illegal-transition flag

Behaviour:
- Reset values: pos=0, dir=0, idx_pos=0, idx_evt=0, err=0. Sync flops = 0, filter counters = 0, filtered lines = 0.
- Reset asserted mid-count returns every channel to the reset state on the next edge. The first samples after reset are treated as a new "previous state", so no count or error is produced from the reset value.
- Sync: each raw line passes through a 2-flop synchroniser.
- Filter, per line:
  - The counter increments while the synchronised value differs from the filtered value, and resets to 0 when they agree.
  - When the counter reaches FILT_LEN, the filtered value takes the synchronised value and the counter returns to 0.
  - A pulse shorter than FILT_LEN cycles is never seen downstream.
  - With FILT_LEN=0, filtered = synchronised.
- Latency: a raw edge stable long enough appears on pos exactly 2+FILT_LEN+1 cycles later (6 at default).
- Decode, prev/cur {A,B} of the filtered lines:
  - Up sequence is 00->10->11->01->00 (A leads B); the reverse sequence counts down.
  - Equal states: no action.
  - Both bits changed (00<->11, 10<->01): no count, err set, prev still updated.
  - dir updates only on a valid step.
- Counter: +1/-1 modulo 2^CNT_W. 0 - 1 gives all ones; max + 1 gives 0.
- Index: a rising edge of filtered Z causes the following:
  - idx_pos <= the counter value after this cycle's count step.
  - idx_evt pulses for 1 cycle.
  - If idx_clr_en, pos <= 0 (overrides the step).
- Priority per channel, per cycle: reset > load > index clear > count step. idx_pos capture happens even when load wins.
- Error: if clear_err and an illegal transition coincide, err stays 1 (set wins).
- Channels are fully independent; no shared state except load_val.

Decomposition:
- Package qei_pkg holds:
  - localparams for the {A,B} Gray states (S00, S10, S11, S01)
  - a step-encode function returning {valid, up, illegal} from prev/cur
  - a filter-counter width helper (clog2(FILT_LEN+1))
- Sub-module qei_channel (sync, filter, decode, counter, index, error for one channel) is instantiated N_CH times in a generate loop. Top level only slices the packed buses.

Test Plan:
1. Forward sequence: ch0 at default params, AB 00->10->11->01->00, each state held 10 cycles -> pos0 = 1,2,3,4, each 6 cycles after its edge; dir0 = 1; other channels unchanged.
2. Reverse wrap: from pos1 = 0, AB 00->01 -> pos1 = 0xFFFFFFFF, dir1 = 0; then 01->00 -> pos1 = 0.
3. Glitch rejection: A pulses high for 2 cycles (FILT_LEN=3) -> pos unchanged, err = 0. A 3-cycle pulse -> pos +1, then -1.
4. Illegal transition: AB 00->11 within 1 cycle -> err = 1, pos unchanged. clear_err pulse -> err = 0. clear_err coincident with a new illegal step -> err stays 1.
5. Index capture:
   - pos2 = 0x123, idx_clr_en2 = 0, Z rises -> idx_pos2 = 0x123, idx_evt2 pulses 1 cycle, pos2 unchanged.
   - Repeat with idx_clr_en2 = 1 and a simultaneous up step -> idx_pos2 = 0x124, pos2 = 0.
6. Load and reset priority: load0 with load_val = 0x80000000 in the same cycle as an up step -> pos0 = 0x80000000. Reset asserted mid-sequence -> all outputs 0 next cycle, and no count or err results from the first post-reset samples.
